pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards in ID, branch/jump redirects resolved in EX, and data-memory wait states in MEM.
- Drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Includes a memory-wait watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/mem_wait_watchdog.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_REDIRECT  = 2'd3
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive data-memory wait cycles spent in MEM_WAIT, saturating at
// MEM_TIMEOUT, and raises a sticky timeout flag once the limit is reached.
module mem_wait_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 32'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait_i,
    input  logic wait_c_i,
    output logic mem_timeout_o
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 32'd1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            to_q;
    logic            to_d;

    // Next count: clear as soon as the wait ends, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!wait_c_i) begin
            cnt_d = '0;
        end else if (in_wait_i && (cnt_q != TO_MAX)) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        to_d = to_q | (cnt_d == TO_MAX);
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign mem_timeout_o = to_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        mem_wb_flush,
    output logic [1:0]  ctrl_state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        wait_c;
    logic        lu_c;
    logic        hit_rs1;
    logic        hit_rs2;

    assign wait_c  = mem_access & ~dmem_ready;
    assign hit_rs1 = id_uses_rs1 & (id_rs1 == ex_rd);
    assign hit_rs2 = id_uses_rs2 & (id_rs2 == ex_rd);
    assign lu_c    = ex_mem_read & (ex_rd != REG_X0) & (hit_rs1 | hit_rs2);

    // Priority decode: a memory wait freezes everything, so any redirect or
    // load-use in the same cycle simply re-presents once the access completes.
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
        end else if (wait_c) begin
            state_d      = ST_MEM_WAIT;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is wrong-path, so a concurrent load-use is moot.
            state_d     = ST_REDIRECT;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_c) begin
            state_d     = ST_LU_BUBBLE;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            state_d = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_state = state_q;

    mem_wait_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .in_wait_i     (state_q == ST_MEM_WAIT),
        .wait_c_i      (wait_c),
        .mem_timeout_o (mem_timeout)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] flush_q;
    logic [31:0] flush_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stall_d = pc_write ? stall_q : (stall_q + 32'd1);
        flush_d = (state_d == ST_REDIRECT) ? (flush_q + 32'd1) : flush_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic        mem_access, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, mem_wb_flush, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
    localparam logic [6:0] CTL_RUN  = 7'b1101010;
    localparam logic [6:0] CTL_LU   = 7'b0001110;
    localparam logic [6:0] CTL_RDR  = 7'b1111110;
    localparam logic [6:0] CTL_WAIT = 7'b0000001;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [31:0] EXP_STALLS  = 32'd2;
    localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(32'd4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_flush (mem_wb_flush),
        .ctrl_state   (ctrl_state),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {25'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_write, mem_wb_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        check_eq("reset_ctl", ctl(), {25'd0, CTL_RUN});
        check_eq("reset_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        check_eq("reset_stalls", stall_cycles, 32'd0);
        check_eq("reset_flushes", flush_count, 32'd0);
        reset = 1'b0;
        tick();

        // Load-use on rs1
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1 check_eq("lu_rs1_ctl", ctl(), {25'd0, CTL_LU});
        tick();
        check_eq("lu_rs1_state", {30'd0, ctrl_state}, 32'd1);
        ex_mem_read = 1'b0;
        #1 check_eq("lu_after_ctl", ctl(), {25'd0, CTL_RUN});
        tick();
        check_eq("lu_after_state", {30'd0, ctrl_state}, 32'd0);

        // rs2 match but rs2 unused: no stall; then used: stall
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd5; id_rs2 = 5'd7;
        id_uses_rs1 = 1'b1;
        #1 check_eq("lu_rs2_unused_ctl", ctl(), {25'd0, CTL_RUN});
        id_uses_rs2 = 1'b1;
        #1 check_eq("lu_rs2_ctl", ctl(), {25'd0, CTL_LU});
        tick();
        check_eq("lu_rs2_state", {30'd0, ctrl_state}, 32'd1);
        idle();

        // Redirect wins over a concurrent load-use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        ex_redirect = 1'b1;
        #1 check_eq("rdr_ctl", ctl(), {25'd0, CTL_RDR});
        tick();
        check_eq("rdr_state", {30'd0, ctrl_state}, 32'd3);
        idle();
        tick();
        check_eq("rdr_after_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("perf_stalls", stall_cycles, EXP_STALLS);
        check_eq("perf_flushes", flush_count, EXP_FLUSHES);

        // Load into x0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1 check_eq("x0_ctl", ctl(), {25'd0, CTL_RUN});
        tick();
        check_eq("x0_state", {30'd0, ctrl_state}, 32'd0);
        idle();

        // Memory wait with a pending redirect, then release
        mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("wait_ctl_%0d", i), ctl(), {25'd0, CTL_WAIT});
            tick();
            check_eq($sformatf("wait_state_%0d", i), {30'd0, ctrl_state}, 32'd2);
        end
        dmem_ready = 1'b1;
        #1 check_eq("wait_release_ctl", ctl(), {25'd0, CTL_RDR});
        tick();
        check_eq("wait_release_state", {30'd0, ctrl_state}, 32'd3);
        check_eq("wait_short_timeout", {31'd0, mem_timeout}, 32'd0);
        idle();
        tick();

        // Watchdog: six wait cycles, flag visible from the sixth
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1 check_eq($sformatf("wd_timeout_c%0d", k), {31'd0, mem_timeout},
                        (k >= 6) ? 32'd1 : 32'd0);
            tick();
        end
        dmem_ready = 1'b1;
        #1 check_eq("wd_release_ctl", ctl(), {25'd0, CTL_RUN});
        tick();
        check_eq("wd_sticky", {31'd0, mem_timeout}, 32'd1);
        check_eq("wd_release_state", {30'd0, ctrl_state}, 32'd0);

        // Reset in the middle of a memory wait
        dmem_ready = 1'b0;
        tick();
        check_eq("mid_rst_pre_state", {30'd0, ctrl_state}, 32'd2);
        reset = 1'b1;
        #1 check_eq("mid_rst_ctl", ctl(), {25'd0, CTL_RUN});
        tick();
        check_eq("mid_rst_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("mid_rst_timeout", {31'd0, mem_timeout}, 32'd0);
        check_eq("mid_rst_stalls", stall_cycles, 32'd0);
        reset = 1'b0;
        idle();
        tick();
        check_eq("post_rst_state", {30'd0, ctrl_state}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
